// File: rtl/crest_sprite_engine.sv
// crest_sprite_engine
//
// Draws NUM_SPRITES copies of one 1-bit crest bitmap at independent positions
// for the VGA overlay mux. Bitmap rows for line y+1 are pre-fetched from an
// external registered ROM during horizontal blanking into per-sprite row
// registers, then the pixel stage tests the current column against them.
//
// Optional feature macro: SPRITE_ANIM_EN
//   defined   - sprites bounce inside [AREA_X0,AREA_X1) x [AREA_Y0,AREA_Y1),
//               moving STEP pixels per axis on every frame_start pulse.
//   undefined - positions are fixed at their reset values, frame_start is
//               ignored and no direction registers are built.
//
// Ports:
//   clk         pixel clock
//   rst_n       asynchronous active-low reset
//   x, y        current pixel column / line
//   active      visible-area flag
//   line_fetch  hblank-start pulse; fetches bitmap rows for line y+1
//   frame_start once-per-frame pulse (animation step)
//   rom_addr    bitmap row address to the registered ROM
//   rom_data    ROM row, one cycle after rom_addr; column c = rom_data[c]
//   fetch_busy  high while a row fetch is in progress
//   draw, rgb   registered overlay hit flag and colour (rgb = 0 when no hit)

module crest_sprite_engine #(
    parameter int             NUM_SPRITES = 3,
    parameter int             SPRITE_W    = 48,
    parameter int             SPRITE_H    = 45,
    parameter int             AREA_X0     = 240,
    parameter int             AREA_X1     = 400,
    parameter int             AREA_Y0     = 144,
    parameter int             AREA_Y1     = 320,
    parameter int             STEP        = 1,
    parameter logic [5:0]     COLOR_EVEN  = 6'b110110,
    parameter logic [5:0]     COLOR_ODD   = 6'b100100
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [9:0]          x,
    input  logic [9:0]          y,
    input  logic                active,
    input  logic                line_fetch,
    input  logic                frame_start,
    output logic [5:0]          rom_addr,
    input  logic [SPRITE_W-1:0] rom_data,
    output logic                fetch_busy,
    output logic                draw,
    output logic [5:0]          rgb
);

    localparam int KW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int IW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam logic [KW-1:0] LAST = KW'(NUM_SPRITES - 1);
    localparam logic [9:0] W10 = 10'(SPRITE_W);
    localparam logic [9:0] H10 = 10'(SPRITE_H);

    typedef enum logic [1:0] {IDLE, ADDR, CAPT} state_t;

    state_t               state;
    state_t               state_next;
    logic [KW-1:0]        k;
    logic [9:0]           ny;
    logic                 hit;
    logic [9:0]           d;
    logic [SPRITE_W-1:0]  row [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] row_valid;
    logic [9:0]           pos_x [NUM_SPRITES];
    logic [9:0]           pos_y [NUM_SPRITES];
    logic                 pix_hit;
    logic [5:0]           pix_color;
    logic [9:0]           off;

    // Sprites start staggered so they do not overlap on the first frame.
    function automatic logic [9:0] init_x(input int i);
        return 10'(AREA_X0 + i * (SPRITE_W + 4));
    endfunction

    function automatic logic [9:0] init_y(input int i);
        return 10'(AREA_Y0 + i * 16);
    endfunction

`ifdef SPRITE_ANIM_EN
    localparam logic [9:0] STEP10 = 10'(STEP);
    localparam logic [9:0] X0_10  = 10'(AREA_X0);
    localparam logic [9:0] X1_10  = 10'(AREA_X1);
    localparam logic [9:0] Y0_10  = 10'(AREA_Y0);
    localparam logic [9:0] Y1_10  = 10'(AREA_Y1);

    logic [NUM_SPRITES-1:0] dir_x;
    logic [NUM_SPRITES-1:0] dir_y;

    // One axis of the bounce: returns {new_dir, new_pos}. A sprite that
    // would leave the area reverses and steps back the other way.
    function automatic logic [10:0] bounce(input logic [9:0] pos, input logic dir,
                                           input logic [9:0] lo, input logic [9:0] hi,
                                           input logic [9:0] size);
        if (dir && (pos + size + STEP10 > hi))
            return {1'b0, pos - STEP10};
        else if (!dir && (pos < lo + STEP10))
            return {1'b1, pos + STEP10};
        else if (dir)
            return {1'b1, pos + STEP10};
        else
            return {1'b0, pos - STEP10};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                pos_x[i] <= init_x(i);
                pos_y[i] <= init_y(i);
                dir_x[i] <= 1'b1;
                dir_y[i] <= 1'b1;
            end
        end else if (frame_start) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                {dir_x[i], pos_x[i]} <= bounce(pos_x[i], dir_x[i], X0_10, X1_10, W10);
                {dir_y[i], pos_y[i]} <= bounce(pos_y[i], dir_y[i], Y0_10, Y1_10, H10);
            end
        end
    end
`else
    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_pos
        assign pos_x[g] = init_x(g);
        assign pos_y[g] = init_y(g);
    end
`endif

    // Bitmap row of sprite k for the upcoming line; wraps to a large value
    // when the line is above the sprite, so one unsigned compare suffices.
    assign d = ny - pos_y[k];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        rom_addr   = 6'd0;
        fetch_busy = (state != IDLE);
        case (state)
            IDLE: if (line_fetch) state_next = ADDR;
            ADDR: begin
                state_next = CAPT;
                if (d < H10) rom_addr = d[5:0];
            end
            CAPT: state_next = (k == LAST) ? IDLE : ADDR;
            default: state_next = IDLE;
        endcase
    end

    // Fetch datapath: latch target line, walk sprites, capture ROM rows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k         <= '0;
            ny        <= 10'd0;
            hit       <= 1'b0;
            row_valid <= '0;
            for (int i = 0; i < NUM_SPRITES; i++) row[i] <= '0;
        end else begin
            case (state)
                IDLE: if (line_fetch) begin
                    ny <= y + 10'd1;
                    k  <= '0;
                end
                ADDR: hit <= (d < H10);
                CAPT: begin
                    row[k]       <= rom_data;
                    row_valid[k] <= hit;
                    if (k != LAST) k <= KW'(k + 1'b1);
                end
                default: ;
            endcase
        end
    end

    // Scan from the highest index down so the lowest hitting sprite wins.
    always_comb begin
        pix_hit   = 1'b0;
        pix_color = 6'd0;
        off       = 10'd0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            off = x - pos_x[i];
            if (active && row_valid[i] && (x >= pos_x[i]) && (off < W10)
                && row[i][off[IW-1:0]]) begin
                pix_hit   = 1'b1;
                pix_color = (i % 2 == 0) ? COLOR_EVEN : COLOR_ODD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            draw <= 1'b0;
            rgb  <= 6'd0;
        end else begin
            draw <= pix_hit;
            rgb  <= pix_hit ? pix_color : 6'd0;
        end
    end

endmodule
